// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- RV32I instruction-decode stage
//
// Decodes the instruction held in IF/ID, reads the 32x32 integer register
// file, resolves jumps and branches combinationally (redirecting fetch in
// the same cycle), and registers the decoded operation into ID/EX.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   pipe_pc/pc4/data      IF/ID contents; pipe_data==0 marks a bubble
//   wb_en/wb_rd/wb_data   register-file writeback port
//   control_j, pc_j       combinational fetch redirect and its target
//   ex_*                  registered ID/EX pipeline outputs
// ---------------------------------------------------------------------------
module id_stage #(
   parameter int XLEN      = 32,
   parameter bit BYPASS_WB = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pipe_pc,
   input  logic [XLEN-1:0] pipe_pc4,
   input  logic [31:0]     pipe_data,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            control_j,
   output logic [XLEN-1:0] pc_j,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_pc4,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_link,
   output logic            ex_illegal
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   // Instruction fields
   logic [6:0] opcode;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] funct3;

   assign opcode = pipe_data[6:0];
   assign rd     = pipe_data[11:7];
   assign funct3 = pipe_data[14:12];
   assign rs1    = pipe_data[19:15];
   assign rs2    = pipe_data[24:20];

   // -------------------------------------------------------------------
   // Register file: x0 is not stored, it is hard-wired to zero on read.
   // -------------------------------------------------------------------
   logic [XLEN-1:0] rf [1:31];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) rf[i] <= '0;
      end else if (wb_en && wb_rd != 5'd0) begin
         rf[wb_rd] <= wb_data;
      end
   end

   logic [XLEN-1:0] rs1_data, rs2_data;

   // A writeback landing in the same cycle wins over the stored value
   // when bypassing is enabled, so back-to-back producers see fresh data.
   assign rs1_data = (rs1 == 5'd0) ? '0 :
                     (BYPASS_WB && wb_en && wb_rd == rs1) ? wb_data : rf[rs1];
   assign rs2_data = (rs2 == 5'd0) ? '0 :
                     (BYPASS_WB && wb_en && wb_rd == rs2) ? wb_data : rf[rs2];

   // -------------------------------------------------------------------
   // Immediates
   // -------------------------------------------------------------------
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{pipe_data[31]}}, pipe_data[31:20]};
   assign imm_s = {{20{pipe_data[31]}}, pipe_data[31:25], pipe_data[11:7]};
   assign imm_b = {{19{pipe_data[31]}}, pipe_data[31], pipe_data[7],
                   pipe_data[30:25], pipe_data[11:8], 1'b0};
   assign imm_u = {pipe_data[31:12], 12'b0};
   assign imm_j = {{11{pipe_data[31]}}, pipe_data[31], pipe_data[19:12],
                   pipe_data[20], pipe_data[30:21], 1'b0};

   // -------------------------------------------------------------------
   // Decode classes
   // -------------------------------------------------------------------
   logic is_bubble, is_lui, is_auipc, is_jal, is_jalr, is_branch;
   logic is_load, is_store, is_opimm, is_op, is_legal, is_illegal;

   assign is_bubble  = (pipe_data == 32'd0);
   assign is_lui     = (opcode == OP_LUI);
   assign is_auipc   = (opcode == OP_AUIPC);
   assign is_jal     = (opcode == OP_JAL);
   assign is_jalr    = (opcode == OP_JALR) && (funct3 == 3'b000);
   // funct3 010/011 are unassigned in the branch space
   assign is_branch  = (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
   assign is_load    = (opcode == OP_LOAD);
   assign is_store   = (opcode == OP_STORE);
   assign is_opimm   = (opcode == OP_OPIMM);
   assign is_op      = (opcode == OP_OP);
   assign is_legal   = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op;
   assign is_illegal = !is_bubble && !is_legal;

   // -------------------------------------------------------------------
   // Branch resolution and redirect
   // -------------------------------------------------------------------
   logic br_taken;

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         3'b000:  br_taken = (rs1_data == rs2_data);
         3'b001:  br_taken = (rs1_data != rs2_data);
         3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  br_taken = (rs1_data <  rs2_data);
         3'b111:  br_taken = (rs1_data >= rs2_data);
         default: br_taken = 1'b0;
      endcase
   end

   logic [XLEN-1:0] jalr_sum;
   assign jalr_sum = rs1_data + imm_i;

   always_comb begin
      pc_j = pipe_pc4;
      if (is_jal)                       pc_j = pipe_pc + imm_j;
      else if (is_jalr)                 pc_j = {jalr_sum[XLEN-1:1], 1'b0};
      else if (is_branch && br_taken)   pc_j = pipe_pc + imm_b;
   end

   assign control_j = !reset && (is_jal || is_jalr || (is_branch && br_taken));

   // -------------------------------------------------------------------
   // ID/EX register
   // -------------------------------------------------------------------
   logic [XLEN-1:0] imm_next;
   logic            reg_write_next;

   always_comb begin
      imm_next = '0;
      if (is_lui || is_auipc)                    imm_next = imm_u;
      else if (is_jal)                           imm_next = imm_j;
      else if (is_jalr || is_load || is_opimm)   imm_next = imm_i;
      else if (is_branch)                        imm_next = imm_b;
      else if (is_store)                         imm_next = imm_s;
   end

   assign reg_write_next = (is_lui | is_auipc | is_jal | is_jalr | is_load |
                            is_opimm | is_op) && (rd != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_pc4       <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_rd        <= '0;
         ex_opcode    <= '0;
         ex_funct3    <= '0;
         ex_funct7b5  <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_link      <= 1'b0;
         ex_illegal   <= 1'b0;
      end else begin
         // Bubbles and illegal slots zero every field; only ex_illegal
         // distinguishes the two.
         ex_valid     <= is_legal;
         ex_pc        <= is_legal ? pipe_pc     : '0;
         ex_pc4       <= is_legal ? pipe_pc4    : '0;
         ex_rs1_data  <= is_legal ? rs1_data    : '0;
         ex_rs2_data  <= is_legal ? rs2_data    : '0;
         ex_imm       <= is_legal ? imm_next    : '0;
         ex_rd        <= is_legal ? rd          : '0;
         ex_opcode    <= is_legal ? opcode      : '0;
         ex_funct3    <= is_legal ? funct3      : '0;
         ex_funct7b5  <= is_legal && pipe_data[30];
         ex_reg_write <= is_legal && reg_write_next;
         ex_mem_read  <= is_legal && is_load;
         ex_mem_write <= is_legal && is_store;
         ex_link      <= is_legal && (is_jal || is_jalr);
         ex_illegal   <= is_illegal;
      end
   end

endmodule
